// File: rtl/rv32i_types.sv
// ---------------------------------------------------------------------------
// rv32i_types
// Shared type package for the mp4 memory hierarchy. Holds the cache line
// geometry constants and the cache-arbiter state / owner enums.
// ---------------------------------------------------------------------------
package rv32i_types;

    // Cache line geometry shared by icache, dcache and the cacheline adaptor.
    localparam int CACHE_LINE_W = 256;
    localparam int CACHE_ADDR_W = 32;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    // Which cache owns (or last owned) the memory port.
    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } arb_owner_t;

    // One-hot grant encoding for an owner: bit0 = icache, bit1 = dcache.
    function automatic logic [1:0] owner_onehot(input arb_owner_t owner);
        return (owner == DCACHE) ? 2'b10 : 2'b01;
    endfunction

endpackage : rv32i_types

// File: rtl/cache_arbiter.sv
// ---------------------------------------------------------------------------
// cache_arbiter
// Shares the single physical-memory line port between the instruction cache
// (read-only) and the data cache (read/write). One line transfer is in flight
// at a time; when both caches request together the one not granted last wins.
// The winning request (address, operation, write line) is latched for the
// whole transfer, and the adaptor's response is routed to the owner only.
//
// Ports
//   clk                      system clock, rising edge
//   rst                      synchronous reset, active low
//   i_read, i_address        icache line-read request (held until i_resp)
//   i_rdata, i_resp          line data / completion pulse back to icache
//   d_read, d_write          dcache read / writeback request (held until d_resp)
//   d_address, d_wdata       dcache line address / writeback line
//   d_rdata, d_resp          line data / completion pulse back to dcache
//   m_read, m_write          request to cacheline adaptor (registered)
//   m_address, m_wdata       latched address / write line of granted request
//   m_rdata, m_resp          line data / completion from the adaptor
//   grant                    one-hot owner (bit0 icache, bit1 dcache), 0 idle
// ---------------------------------------------------------------------------
module cache_arbiter
    import rv32i_types::*;
#(
    parameter int LINE_W = CACHE_LINE_W,
    parameter int ADDR_W = CACHE_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_address,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_resp,

    output logic [1:0]        grant
);

    arb_state_t        state_reg;
    arb_owner_t        last_grant_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [LINE_W-1:0] wdata_reg;
    logic              m_read_reg;
    logic              m_write_reg;
    logic [1:0]        grant_reg;

    logic              i_pend;
    logic              d_pend;
    logic              pick_d;

    assign i_pend = i_read;
    assign d_pend = d_read | d_write;

    // Dcache wins when it is the only requester, or on a conflict when the
    // icache was the previous owner (round robin between two requesters).
    assign pick_d = d_pend && (!i_pend || (last_grant_reg == ICACHE));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= ICACHE;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            m_read_reg     <= 1'b0;
            m_write_reg    <= 1'b0;
            grant_reg      <= 2'b00;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_d) begin
                        state_reg      <= SERVE_D;
                        last_grant_reg <= DCACHE;
                        addr_reg       <= d_address;
                        wdata_reg      <= d_wdata;
                        // Read+write together is illegal; resolve as a write.
                        m_write_reg    <= d_write;
                        m_read_reg     <= ~d_write;
                        grant_reg      <= owner_onehot(DCACHE);
                    end else if (i_pend) begin
                        state_reg      <= SERVE_I;
                        last_grant_reg <= ICACHE;
                        addr_reg       <= i_address;
                        m_write_reg    <= 1'b0;
                        m_read_reg     <= 1'b1;
                        grant_reg      <= owner_onehot(ICACHE);
                    end
                end

                SERVE_I, SERVE_D: begin
                    if (m_resp) begin
                        state_reg   <= DONE;
                        m_read_reg  <= 1'b0;
                        m_write_reg <= 1'b0;
                        grant_reg   <= 2'b00;
                    end
                end

                // Dead cycle so the served cache can drop its request before
                // the next arbitration decision.
                DONE: begin
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign m_read    = m_read_reg;
    assign m_write   = m_write_reg;
    assign m_address = addr_reg;
    assign m_wdata   = wdata_reg;
    assign grant     = grant_reg;

    // Completion is forwarded in the same cycle as the adaptor's response.
    assign i_resp  = (state_reg == SERVE_I) && m_resp;
    assign d_resp  = (state_reg == SERVE_D) && m_resp;
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

`ifndef SYNTHESIS
    // The dcache must never ask for a read and a writeback at once.
    a_no_dual_d_op : assert property (@(posedge clk) disable iff (!rst)
        !(d_read && d_write));
`endif

endmodule : cache_arbiter

// File: tb/tb_cache_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_arbiter
// Directed + randomized bench for cache_arbiter. The bench plays both caches
// and the cacheline adaptor. A small reference model predicts the owner of
// each transfer from the pending requests and the previous owner, and the
// address / operation / write line that must appear on the memory port.
// ---------------------------------------------------------------------------
module tb_cache_arbiter;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              m_read;
    logic              m_write;
    logic [ADDR_W-1:0] m_address;
    logic [LINE_W-1:0] m_wdata;
    logic [LINE_W-1:0] m_rdata;
    logic              m_resp;
    logic [1:0]        grant;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: 1 when the dcache owned the most recent transfer.
    bit last_d;

    cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_read    (i_read),
        .i_address (i_address),
        .i_rdata   (i_rdata),
        .i_resp    (i_resp),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_address (d_address),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_resp    (d_resp),
        .m_read    (m_read),
        .m_write   (m_write),
        .m_address (m_address),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_resp    (m_resp),
        .grant     (grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m_read"},  m_read,    0);
        chk({tag, "_m_write"}, m_write,   0);
        chk({tag, "_m_addr"},  m_address, 0);
        chk({tag, "_m_wdata"}, m_wdata,   0);
        chk({tag, "_grant"},   grant,     0);
        chk({tag, "_i_resp"},  i_resp,    0);
        chk({tag, "_d_resp"},  d_resp,    0);
    endtask

    // Hold reset for n cycles (checking outputs each cycle), leave it
    // asserted; the caller releases it on a falling edge.
    task automatic hold_reset(input int n);
        rst = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk_all_zero("reset");
        end
        last_d = 1'b0;
    endtask

    // One complete transfer, called on a falling edge with requests driven.
    // The adaptor answers after lat cycles of the serve phase.
    task automatic serve(input int lat, input logic [LINE_W-1:0] rdata,
                         output int waited, output bit owner_d);
        bit                exp_d;
        bit                exp_w;
        logic [ADDR_W-1:0] exp_a;
        logic [LINE_W-1:0] exp_wd;

        exp_d  = (d_read || d_write) && (!i_read || !last_d);
        exp_w  = exp_d && d_write;
        exp_a  = exp_d ? d_address : i_address;
        exp_wd = d_wdata;
        last_d  = exp_d;
        owner_d = exp_d;

        waited = 0;
        while (grant == 2'b00 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("grant_timeout", (waited < 20), 1);
        chk("grant",   grant,   exp_d ? 2'b10 : 2'b01);
        chk("m_read",  m_read,  !exp_w);
        chk("m_write", m_write, exp_w);
        chk("m_addr",  m_address, exp_a);
        if (exp_d) chk("m_wdata", m_wdata, exp_wd);

        // Owner changes its live inputs; the latched request must not move.
        if (exp_d) begin
            d_address = exp_a ^ 32'h0000_0700;
            d_wdata   = rand_line();
        end else begin
            i_address = exp_a ^ 32'h0000_0700;
        end

        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            chk("hold_addr",  m_address, exp_a);
            chk("hold_read",  m_read,  !exp_w);
            chk("hold_write", m_write, exp_w);
            if (exp_d) chk("hold_wdata", m_wdata, exp_wd);
            chk("early_i_resp", i_resp, 0);
            chk("early_d_resp", d_resp, 0);
        end

        m_rdata = rdata;
        m_resp  = 1'b1;
        #1;
        chk("i_resp", i_resp, !exp_d);
        chk("d_resp", d_resp, exp_d);
        chk("rdata", exp_d ? d_rdata : i_rdata, rdata);

        // DONE cycle: port quiet, a lingering m_resp must be ignored.
        @(negedge clk);
        if (exp_d) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end else begin
            i_read = 1'b0;
        end
        chk("done_m_read",  m_read,  0);
        chk("done_m_write", m_write, 0);
        chk("done_i_resp",  i_resp,  0);
        chk("done_d_resp",  d_resp,  0);
        m_resp = 1'b0;
    endtask

    task automatic req_i();
        i_read    = 1'b1;
        i_address = $urandom & 32'hFFFF_FFE0;
    endtask

    task automatic req_d();
        bit wr;
        wr        = $urandom_range(0, 1) == 1;
        d_read    = !wr;
        d_write   = wr;
        d_address = $urandom & 32'hFFFF_FFE0;
        d_wdata   = rand_line();
    endtask

    initial begin
        int                waited;
        int                cnt;
        bit                own;
        logic [LINE_W-1:0] pat;

        rst = 1'b0; i_read = 0; i_address = 0; d_read = 0; d_write = 0;
        d_address = 0; d_wdata = 0; m_rdata = 0; m_resp = 0; last_d = 0;

        // Reset with a pending icache request, then the request is served.
        @(negedge clk);
        i_read    = 1'b1;
        i_address = 32'h0000_0060;
        hold_reset(3);
        rst = 1'b1;
        pat = {8{32'hA5A5_0060}};
        serve(10, pat, waited, own);
        chk("first_latency", waited, 1);
        chk("first_owner", own, 0);
        @(negedge clk);
        chk("idle_grant",  grant,  0);
        chk("idle_m_read", m_read, 0);
        m_resp = 1'b1;
        #1;
        chk("idle_i_resp", i_resp, 0);
        chk("idle_d_resp", d_resp, 0);
        @(negedge clk);
        m_resp = 1'b0;

        // Simultaneous requests after reset: dcache write goes first.
        hold_reset(2);
        rst       = 1'b1;
        i_read    = 1'b1;
        i_address = 32'h0000_0100;
        d_write   = 1'b1;
        d_address = 32'h0000_0200;
        d_wdata   = {8{32'hB00B_0200}};
        serve(4, rand_line(), waited, own);
        chk("conflict_first_d", own, 1);
        serve(3, rand_line(), waited, own);
        chk("conflict_then_i", own, 0);
        chk("conflict_gap", waited, 2);

        // Continuous contention: strict alternation D, I, D, I, D, I.
        req_i();
        req_d();
        for (int k = 0; k < 6; k++) begin
            serve($urandom_range(1, 5), rand_line(), waited, own);
            chk("alternate", own, (k % 2 == 0));
            if (own) req_d(); else req_i();
        end
        @(negedge clk);
        i_read = 0; d_read = 0; d_write = 0;
        repeat (3) @(negedge clk);

        // Dcache address moves 0x300 -> 0x400 mid-transfer.
        d_read    = 1'b1;
        d_address = 32'h0000_0300;
        serve(6, rand_line(), waited, own);
        chk("addr_change_owner", own, 1);
        chk("addr_change_live", d_address, 32'h0000_0400);

        // Reset four cycles into SERVE_I abandons the transfer.
        @(negedge clk);
        i_read    = 1'b1;
        i_address = 32'h0000_0500;
        cnt = 0;
        while (grant != 2'b01 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("abort_grant_timeout", (cnt < 20), 1);
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        i_read = 1'b0;
        @(negedge clk);
        rst    = 1'b1;
        last_d = 1'b0;
        chk("abort_m_read", m_read, 0);
        chk("abort_grant",  grant,  0);
        m_resp = 1'b1;
        #1;
        chk("abort_i_resp", i_resp, 0);
        @(negedge clk);
        chk("abort_i_resp_late", i_resp, 0);
        m_resp = 1'b0;
        @(negedge clk);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 40; n++) begin
            if (!i_read && !d_read && !d_write) begin
                case ($urandom_range(0, 2))
                    0: req_i();
                    1: req_d();
                    default: begin req_i(); req_d(); end
                endcase
            end
            serve($urandom_range(1, 8), rand_line(), waited, own);
            if (!i_read && ($urandom_range(0, 1) == 1)) req_i();
            if (!d_read && !d_write && ($urandom_range(0, 1) == 1)) req_d();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_cache_arbiter
